// File: rtl/adc_frame_align.sv
// rtl/adc_frame_align.sv - ADC frame-clock word alignment with lock tracking
module adc_frame_align #(
    parameter int         NUM_LANES  = 2,
    parameter logic [9:0] PATTERN    = 10'h01F,
    parameter int         LOCK_COUNT = 4,
    parameter int         MISS_LIMIT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [9:0]              frame_in,
    input  logic [10*NUM_LANES-1:0] data_in,
    input  logic                    resync,
    output logic [10*NUM_LANES-1:0] data_out,
    output logic                    out_valid,
    output logic                    locked,
    output logic [3:0]              offset,
    output logic [7:0]              slip_count
);

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic [7:0] MISS_TARGET = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [9:0]              prev_frame;
    logic [10*NUM_LANES-1:0] prev_data;
    logic [10*NUM_LANES-1:0] data_win;
    logic [19:0]             frame_hist;
    logic [9:0]              frame_win;
    logic [4:0]              win_base;
    logic                    hit;
    logic                    accept;
    logic [3:0]              offset_nxt;
    logic [3:0]              offset_adv;
    logic [7:0]              slip_nxt;
    logic [7:0]              slip_adv;
    logic [7:0]              match_cnt;
    logic [7:0]              match_nxt;
    logic [7:0]              miss_cnt;
    logic [7:0]              miss_nxt;
    logic                    primed;
    logic                    primed_nxt;
    logic                    out_valid_nxt;

    // History is {current, previous}: older serial bits sit in the low half,
    // so a window at offset k straddles the word boundary by k bits.
    assign win_base   = {1'b0, offset};
    assign frame_hist = {frame_in, prev_frame};
    assign frame_win  = frame_hist[win_base +: 10];
    assign hit        = (frame_win == PATTERN);

    // resync wins over a coincident word, so such a word is not accepted.
    assign accept     = in_valid && !resync;

    // Same offset applied to every data lane as to the frame lane.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        logic [19:0] lane_hist;
        assign lane_hist             = {data_in[10*n +: 10], prev_data[10*n +: 10]};
        assign data_win[10*n +: 10]  = lane_hist[win_base +: 10];
    end

    assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    assign slip_adv   = (slip_count == 8'hFF) ? 8'hFF : slip_count + 8'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and qualifier decisions for each accepted word.
    always_comb begin
        state_nxt     = state;
        offset_nxt    = offset;
        slip_nxt      = slip_count;
        match_nxt     = match_cnt;
        miss_nxt      = miss_cnt;
        primed_nxt    = primed;
        out_valid_nxt = 1'b0;
        if (resync) begin
            state_nxt  = SEARCH;
            offset_nxt = 4'd0;
            match_nxt  = 8'd0;
            miss_nxt   = 8'd0;
            primed_nxt = 1'b0;
        end else if (in_valid) begin
            if (!primed) begin
                primed_nxt = 1'b1;
            end else begin
                case (state)
                    SEARCH: begin
                        if (hit) begin
                            state_nxt = VERIFY;
                            match_nxt = 8'd1;
                        end else begin
                            offset_nxt = offset_adv;
                            slip_nxt   = slip_adv;
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            match_nxt = match_cnt + 8'd1;
                            if (match_cnt + 8'd1 == LOCK_TARGET) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            match_nxt  = 8'd0;
                            offset_nxt = offset_adv;
                            slip_nxt   = slip_adv;
                            state_nxt  = SEARCH;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_nxt      = 8'd0;
                            out_valid_nxt = 1'b1;
                        end else if (miss_cnt + 8'd1 == MISS_TARGET) begin
                            // Lock lost: keep the offset, search from where we were.
                            miss_nxt  = 8'd0;
                            state_nxt = SEARCH;
                        end else begin
                            miss_nxt      = miss_cnt + 8'd1;
                            out_valid_nxt = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = SEARCH;
                    end
                endcase
            end
        end
    end

    // Control registers: offset, counters, primed flag and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset     <= 4'd0;
            slip_count <= 8'd0;
            match_cnt  <= 8'd0;
            miss_cnt   <= 8'd0;
            primed     <= 1'b0;
            locked     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            offset     <= offset_nxt;
            slip_count <= slip_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            primed     <= primed_nxt;
            locked     <= (state_nxt == LOCKED);
            out_valid  <= out_valid_nxt;
        end
    end

    // Word history and aligned data capture on each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_frame <= 10'd0;
            prev_data  <= '0;
            data_out   <= '0;
        end else if (accept) begin
            prev_frame <= frame_in;
            prev_data  <= data_in;
            data_out   <= data_win;
        end
    end

endmodule

// File: tb/tb_adc_frame_align.sv
// tb/tb_adc_frame_align.sv - self-checking bench for adc_frame_align
module tb_adc_frame_align;

    localparam int         NL    = 2;
    localparam logic [9:0] PAT   = 10'h01F;
    localparam int         LOCKN = 4;
    localparam int         MISSN = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [9:0]       frame_in;
    logic [10*NL-1:0] data_in;
    logic             resync;
    logic [10*NL-1:0] data_out;
    logic             out_valid;
    logic             locked;
    logic [3:0]       offset;
    logic [7:0]       slip_count;

    int n_checks = 0;
    int n_fail   = 0;

    adc_frame_align #(
        .NUM_LANES (NL),
        .PATTERN   (PAT),
        .LOCK_COUNT(LOCKN),
        .MISS_LIMIT(MISSN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .frame_in  (frame_in),
        .data_in   (data_in),
        .resync    (resync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .locked    (locked),
        .offset    (offset),
        .slip_count(slip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rs;
        bit         v;
        logic [9:0] f;
        bit         lk;
        bit         ov;
        int         off;
        int         slip;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (spec-level: plain integers and arithmetic).
    int  m_mode;        // 0 hunting, 1 confirming, 2 locked
    int  m_off;
    int  m_slip;
    int  m_good;
    int  m_bad;
    bit  m_primed;
    int  m_prev_f;
    int  m_prev_d[NL];
    bit  e_locked;
    bit  e_ov;
    logic [10*NL-1:0] e_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(bit rs, bit v, logic [9:0] f, bit lk, bit ov, int off, int slip);
        vec_t r;
        r.rs = rs; r.v = v; r.f = f; r.lk = lk; r.ov = ov; r.off = off; r.slip = slip;
        tbl.push_back(r);
    endtask

    task automatic apply(bit rs, bit v, logic [9:0] f, logic [10*NL-1:0] d);
        @(negedge clk);
        resync   = rs;
        in_valid = v;
        frame_in = f;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        resync   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bits k..k+9 of the 20-bit serial history {cur, prev}.
    function automatic int win(int cur, int prev, int k);
        return ((cur * 1024 + prev) / (1 << k)) % 1024;
    endfunction

    // Word seen when the frame stream (PATTERN repeated) is cut at bit phase p.
    function automatic logic [9:0] rot_word(int p);
        logic [9:0] pat;
        logic [9:0] w;
        pat = PAT;
        for (int j = 0; j < 10; j++) w[j] = pat[(p + j) % 10];
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_slip = 0; m_good = 0; m_bad = 0;
        m_primed = 0; m_prev_f = 0;
        for (int n = 0; n < NL; n++) m_prev_d[n] = 0;
        e_locked = 0; e_ov = 0; e_data = '0;
    endtask

    task automatic model_slip();
        m_off = (m_off + 1) % 10;
        if (m_slip < 255) m_slip++;
    endtask

    task automatic model_step(bit rs, bit v, logic [9:0] f, logic [10*NL-1:0] d);
        int lane;
        bit hit;
        e_ov = 0;
        if (rs) begin
            m_mode = 0; m_off = 0; m_good = 0; m_bad = 0; m_primed = 0;
        end else if (v) begin
            hit = (win(int'(f), m_prev_f, m_off) == int'(PAT));
            for (int n = 0; n < NL; n++) begin
                lane = int'(d[10*n +: 10]);
                e_data[10*n +: 10] = 10'(win(lane, m_prev_d[n], m_off));
                m_prev_d[n] = lane;
            end
            if (!m_primed) begin
                m_primed = 1;
            end else if (m_mode == 0) begin
                if (hit) begin m_mode = 1; m_good = 1; end
                else model_slip();
            end else if (m_mode == 1) begin
                if (hit) begin
                    m_good++;
                    if (m_good == LOCKN) m_mode = 2;
                end else begin
                    m_good = 0; m_mode = 0; model_slip();
                end
            end else begin
                if (hit) begin
                    m_bad = 0; e_ov = 1;
                end else begin
                    m_bad++;
                    if (m_bad == MISSN) begin m_mode = 0; m_bad = 0; end
                    else e_ov = 1;
                end
            end
            m_prev_f = int'(f);
        end
        e_locked = (m_mode == 2);
    endtask

    initial begin
        logic [10*NL-1:0] dconst;
        logic [10*NL-1:0] d;
        logic [9:0]       f;
        bit               rs;
        bit               v;
        int               p;

        rst = 1'b1; in_valid = 1'b0; resync = 1'b0; frame_in = '0; data_in = '0;
        do_reset();

        // Reset state
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_offset", 32'(offset), 32'd0);
        check("rst_slip", 32'(slip_count), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);

        // Table: acquire at offset 3, transient misses, lock loss, relock, idle, resync.
        add(0, 1, 10'h0F8, 0, 0, 0, 0);
        add(0, 1, 10'h0F8, 0, 0, 1, 1);
        add(0, 1, 10'h0F8, 0, 0, 2, 2);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 1, 0, 3, 3);
        add(0, 1, 10'h0F8, 1, 1, 3, 3);
        add(0, 1, 10'h0FF, 1, 1, 3, 3);
        add(0, 1, 10'h0F8, 1, 1, 3, 3);
        add(0, 1, 10'h0FF, 1, 1, 3, 3);
        add(0, 1, 10'h0FF, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 0, 0, 3, 3);
        add(0, 1, 10'h0F8, 1, 0, 3, 3);
        add(0, 1, 10'h0F8, 1, 1, 3, 3);
        add(0, 0, 10'h0F8, 1, 0, 3, 3);
        add(1, 1, 10'h0F8, 0, 0, 0, 3);
        add(0, 1, 10'h0F8, 0, 0, 0, 3);
        add(0, 1, 10'h0F8, 0, 0, 1, 4);

        dconst = {10'h3FF, 10'h2A8};
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rs, tbl[i].v, tbl[i].f, dconst);
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_offset", i), 32'(offset), 32'(tbl[i].off));
            check($sformatf("tbl%0d_slip", i), 32'(slip_count), 32'(tbl[i].slip));
            if (tbl[i].ov) begin
                check($sformatf("tbl%0d_lane0", i), 32'(data_out[9:0]), 32'h055);
                check($sformatf("tbl%0d_lane1", i), 32'(data_out[19:10]), 32'h3FF);
            end
        end

        // Pattern never present: offset walks 0..9 and slip_count saturates.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 10'h000, 20'($urandom));
            check($sformatf("sat%0d_offset", i), 32'(offset), 32'(i % 10));
            check($sformatf("sat%0d_slip", i), 32'(slip_count), 32'((i < 255) ? i : 255));
            check($sformatf("sat%0d_locked", i), 32'(locked), 32'd0);
        end

        // Asynchronous reset while locked and streaming.
        do_reset();
        for (int i = 0; i < 9; i++) apply(0, 1, 10'h0F8, dconst);
        check("arst_pre_locked", 32'(locked), 32'd1);
        check("arst_pre_out_valid", 32'(out_valid), 32'd1);
        check("arst_pre_slip", 32'(slip_count), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_offset", 32'(offset), 32'd0);
        check("arst_slip", 32'(slip_count), 32'd0);
        check("arst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        // Randomized stream against the reference model.
        do_reset();
        model_reset();
        p = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) p = $urandom_range(0, 9);
            rs = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 4) != 0);
            f  = rot_word(p);
            if ($urandom_range(0, 24) == 0) f = 10'($urandom);
            d  = 20'($urandom);
            model_step(rs, v, f, d);
            apply(rs, v, f, d);
            check($sformatf("rnd%0d_locked", c), 32'(locked), 32'(e_locked));
            check($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(e_ov));
            check($sformatf("rnd%0d_offset", c), 32'(offset), 32'(m_off));
            check($sformatf("rnd%0d_slip", c), 32'(slip_count), 32'(m_slip));
            if (e_ov) check($sformatf("rnd%0d_data", c), 32'(data_out), 32'(e_data));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
